sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

- Serial-in, parallel-out deserializer; downstream consumer of the enable-qualified D flip-flop stage.
- Samples the registered serial bit on every clock edge where the bit strobe is high and assembles WIDTH-bit words.
- Presents each completed word through a one-entry valid/ready output buffer, so a new word can shift in while the previous word waits.
- Flags dropped words (overrun) and, when compiled in, even-parity errors.

## Interface

Parameters:
- WIDTH, 8: data bits per word; legal range 2 to 32.
- MSB_FIRST, 1: 1 means the first received bit lands in word_out[WIDTH-1]; 0 means the first bit lands in word_out[0].

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit strobe; d is sampled only on edges where en=1.
- d  in  1  serial data bit, driven by the upstream flip-flop's q.
- word_out  out  WIDTH  assembled word; stable while word_valid=1.
- word_valid  out  1  word_out holds an undelivered word.
- word_ready  in  1  consumer accepts the word on an edge where word_valid=1 and word_ready=1.
- overrun  out  1  sticky; at least one completed word was dropped.
- parity_err  out  1  parity result for the word in word_out; qualified by word_valid.

## Operation

Reset:
- rst=1 at an edge clears the shift register, bit counter, word_out, word_valid, overrun and parity_err to 0.
- rst overrides en and word_ready.
- Reset mid-frame discards the partial bits; the next en=1 bit after reset is bit 0 of a new frame.

Shift path:
- Each en=1 edge shifts d into the shift register and increments the bit counter.
- MSB_FIRST=1: shift left, d enters at bit 0.
- MSB_FIRST=0: shift right, d enters at bit WIDTH-1.
- en=0 edges hold all shift state. Gaps of any length between bits are legal.

State machine (state register plus bit counter of width clog2(WIDTH)):
- S_DATA: collect data bits. On the en=1 edge of data bit WIDTH-1:
  - without parity: the frame completes, the counter wraps to 0, and the state stays S_DATA;
  - with parity: go to S_PAR.
- S_PAR (parity build only): the next en=1 bit is the parity bit. The frame completes, and the state returns to S_DATA with the counter at 0.

Frame completion, evaluated on the completing edge:
- Buffer empty (word_valid=0), or being drained on the same edge (word_valid=1 and word_ready=1):
  - load word_out with the complete word, including the bit arriving on this edge;
  - set word_valid=1;
  - load parity_err.
- Buffer full and not drained (word_valid=1 and word_ready=0):
  - drop the new word;
  - set overrun=1;
  - leave word_out, word_valid and parity_err unchanged.
- overrun clears only on rst.

Acceptance without completion:
- word_valid=1 and word_ready=1 with no completing edge: word_valid goes to 0 and word_out holds its last value.

## Timing

- Latency: word_valid and word_out are updated on the same edge that samples the final bit of the frame, and are visible the following cycle.
- Throughput: one word per WIDTH en-strobes (WIDTH+1 with parity). Back-to-back frames need no idle cycle.
- word_ready may be held high permanently. The buffer then never drops words.
- Nothing is combinational from input to output; all outputs are registered.

## Configuration

- Macro: SIPO_PARITY_EN.
- Defined:
  - each frame is WIDTH data bits followed by one even-parity bit;
  - parity_err = XOR of the data bits and the parity bit, registered with word_out;
  - the S_PAR state exists.
- Undefined:
  - each frame is WIDTH data bits with no parity bit;
  - S_PAR is absent;
  - parity_err is tied to 0.
- The port list is identical in both builds.

## Structure

- Package sipo_pkg holds:
  - the state encodings S_DATA=1'b0 and S_PAR=1'b1;
  - the default WIDTH constant;
  - the clog2 helper function used to size the counter.
- One sub-module: sipo_out_buf, the one-entry valid/ready holding register. It owns word_out, word_valid, parity_err and overrun.
- The top level owns the shift register, bit counter and FSM.

## Test plan

All cases use WIDTH=8, MSB_FIRST=1 and word_ready=1 unless stated otherwise.

- Basic word: bits 1,0,1,0,0,1,0,1 with en=1 on every edge. Expect word_out=8'hA5 and word_valid=1 one cycle after the 8th bit; overrun=0.
- Gapped strobe: same bits with en toggling 1,0,1,0,... Expect word_out=8'hA5, with completion on the 8th en=1 edge only.
- LSB-first: MSB_FIRST=0, bits 1,0,1,0,0,1,0,1. Expect word_out=8'hA5.
- Backpressure: word_ready=0, send 8'h3C then 8'hFF. Expect word_out to stay 8'h3C, overrun=1 after the second frame, and word_valid=1. Then raise word_ready for one edge: expect word_valid=0, with overrun still 1.
- Simultaneous drain and complete: word_valid=1 holding 8'h11, and word_ready=1 on the edge completing 8'h22. Expect word_out=8'h22, word_valid=1, overrun=0.
- Reset mid-frame: send 5 bits, assert rst for one edge, then send a full 8'hC3. Expect all outputs 0 after reset, then word_out=8'hC3.
- Parity, with SIPO_PARITY_EN defined: send 8'hA5 then parity bit 0. Expect parity_err=0. Send 8'hA5 then parity bit 1. Expect parity_err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial-in parallel-out deserializer.
//   state_e            - frame state encoding (S_DATA collects data bits,
//                        S_PAR takes the parity bit in parity builds)
//   SIPO_WIDTH_DEFAULT - default word width
//   clog2()            - ceiling log2, used to size the bit counter
package sipo_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_e;

  localparam int unsigned SIPO_WIDTH_DEFAULT = 8;

  // Ceiling log2 for values >= 2; returns the number of bits needed to count
  // 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: one-entry valid/ready holding register for completed words.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   load_i         - a frame completes on this edge
//   word_i         - completed word (including the bit arriving this edge)
//   par_err_i      - parity result for word_i
//   ready_i        - consumer accepts the held word when valid_o=1
//   word_o         - held word, stable while valid_o=1
//   valid_o        - word_o holds an undelivered word
//   par_err_o      - parity result registered with word_o
//   overrun_o      - sticky: a completed word was dropped (cleared by reset)
module sipo_out_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             par_err_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             par_err_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] word_q;
  logic             valid_q;
  logic             par_err_q;
  logic             overrun_q;
  logic             room;

  // The slot can take a new word if it is empty or drained on this same edge.
  assign room = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (load_i && room) begin
      word_q    <= word_i;
      valid_q   <= 1'b1;
      par_err_q <= par_err_i;
    end else begin
      if (load_i) overrun_q <= 1'b1;
      if (valid_q && ready_i) valid_q <= 1'b0;
    end
  end

  assign word_o    = word_q;
  assign valid_o   = valid_q;
  assign par_err_o = par_err_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: samples d on every clk edge with en=1 and assembles
// WIDTH-bit words, delivered through a one-entry valid/ready buffer.
// Build option: define SIPO_PARITY_EN to expect one even-parity bit after
// the data bits of each frame; otherwise parity_err is tied to 0.
//   clk        - clock, all state updates on rising edge
//   rst        - synchronous active-high reset
//   en         - bit strobe; d sampled only when en=1
//   d          - serial data bit
//   word_out   - assembled word, stable while word_valid=1
//   word_valid - word_out holds an undelivered word
//   word_ready - consumer accepts on an edge with word_valid=1
//   overrun    - sticky dropped-word flag
//   parity_err - parity result for word_out, qualified by word_valid
// Parameters: WIDTH (2..32), MSB_FIRST (1: first bit lands in MSB).
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned     CW       = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done;
  logic [WIDTH-1:0] done_word;
  logic             done_par;
`ifdef SIPO_PARITY_EN
  state_e           state_q, state_d;
`endif

  // Register contents after d is shifted in on this edge.
  always_comb begin
    if (MSB_FIRST) shift_in = {shift_q[WIDTH-2:0], d};
    else           shift_in = {d, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    done_word = shift_in;
    done_par  = 1'b0;
`ifdef SIPO_PARITY_EN
    state_d   = state_q;
    if (en) begin
      case (state_q)
        S_DATA: begin
          shift_d = shift_in;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = S_PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          // Data bits are already complete in shift_q; d is the parity bit.
          done      = 1'b1;
          done_word = shift_q;
          done_par  = (^shift_q) ^ d;
          state_d   = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
`else
    if (en) begin
      shift_d = shift_in;
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
      state_q <= S_DATA;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef SIPO_PARITY_EN
      state_q <= state_d;
`endif
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (done),
    .word_i    (done_word),
    .par_err_i (done_par),
    .ready_i   (word_ready),
    .word_o    (word_out),
    .valid_o   (word_valid),
    .par_err_o (parity_err),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;
  import sipo_pkg::*;

`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_m = 1'b0, en_l = 1'b0;
  logic       d = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] wo_m, wo_l;
  logic       v_m, v_l, ov_m, ov_l, pe_m, pe_l;

  int errors = 0;
  int checks = 0;

  // Scoreboards: {parity_err, word} expected per instance.
  logic [8:0] q_m[$];
  logic [8:0] q_l[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .en(en_m), .d(d),
    .word_out(wo_m), .word_valid(v_m), .word_ready(ready),
    .overrun(ov_m), .parity_err(pe_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en_l), .d(d),
    .word_out(wo_l), .word_valid(v_l), .word_ready(ready),
    .overrun(ov_l), .parity_err(pe_l)
  );

  // Output monitors: a new word is presented when valid rises, or when valid
  // stays high across an edge that accepted the previous word.
  logic pv_m = 1'b0, pacc_m = 1'b0, pv_l = 1'b0, pacc_l = 1'b0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (v_m === 1'b1 && (!pv_m || pacc_m)) begin
      checks++;
      if (q_m.size() == 0) begin
        errors++;
        $display("FAIL mon_msb: got word %h perr %b, required no word", wo_m, pe_m);
      end else begin
        e = q_m.pop_front();
        if ({pe_m, wo_m} !== e) begin
          errors++;
          $display("FAIL mon_msb: got perr/word %b/%h, required %b/%h", pe_m, wo_m, e[8], e[7:0]);
        end
      end
    end
    if (v_l === 1'b1 && (!pv_l || pacc_l)) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++;
        $display("FAIL mon_lsb: got word %h perr %b, required no word", wo_l, pe_l);
      end else begin
        e = q_l.pop_front();
        if ({pe_l, wo_l} !== e) begin
          errors++;
          $display("FAIL mon_lsb: got perr/word %b/%h, required %b/%h", pe_l, wo_l, e[8], e[7:0]);
        end
      end
    end
    pv_m = (v_m === 1'b1); pacc_m = (v_m === 1'b1) && ready;
    pv_l = (v_l === 1'b1); pacc_l = (v_l === 1'b1) && ready;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en_m = 1'b0; en_l = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // en is left high so consecutive bits need no idle edge.
  task automatic send_bit(input int which, input logic b);
    if (which == 0) en_m = 1'b1; else en_l = 1'b1;
    d = b;
    tick();
  endtask

  task automatic send_word(input int which, input logic [7:0] data, input logic bad);
    logic [7:0] w;
    w = data;
    for (int i = 0; i < 8; i++) send_bit(which, (which == 0) ? w[7-i] : w[i]);
    if (PAR) send_bit(which, (^w) ^ bad);
    en_m = 1'b0; en_l = 1'b0;
  endtask

  function automatic logic [8:0] exp_of(input logic [7:0] data, input logic bad);
    return {PAR & bad, data};
  endfunction

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    tick(); tick();
    checks++;
    if ({wo_m, v_m, ov_m, pe_m} !== 11'd0) begin
      errors++; $display("FAIL reset_msb: got %h, required 0", {wo_m, v_m, ov_m, pe_m});
    end
    checks++;
    if ({wo_l, v_l, ov_l, pe_l} !== 11'd0) begin
      errors++; $display("FAIL reset_lsb: got %h, required 0", {wo_l, v_l, ov_l, pe_l});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    q_m.push_back(exp_of(8'hA5, 1'b0));
    send_word(0, 8'hA5, 1'b0);
    checks++;
    if (v_m !== 1'b1 || wo_m !== 8'hA5) begin
      errors++; $display("FAIL basic_latency: got valid %b word %h, required 1 a5", v_m, wo_m);
    end
    checks++;
    if (ov_m !== 1'b0) begin
      errors++; $display("FAIL basic_overrun: got %b, required 0", ov_m);
    end
    idle(2);
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'hA5;
    ready = 1'b1;
    q_m.push_back(exp_of(w, 1'b0));
    for (int i = 0; i < 8; i++) begin
      send_bit(0, w[7-i]);
      en_m = 1'b0;
      if (i < 7) begin
        tick();
        checks++;
        if (v_m !== 1'b0) begin
          errors++; $display("FAIL gapped_early: bit %0d got valid %b, required 0", i, v_m);
        end
      end
    end
    if (PAR) begin
      tick();
      send_bit(0, ^w);
      en_m = 1'b0;
    end
    checks++;
    if (v_m !== 1'b1 || wo_m !== 8'hA5) begin
      errors++; $display("FAIL gapped_done: got valid %b word %h, required 1 a5", v_m, wo_m);
    end
    idle(2);
  endtask

  task automatic test_lsb_first();
    ready = 1'b1;
    q_l.push_back(exp_of(8'hA5, 1'b0));
    send_word(1, 8'hA5, 1'b0);
    checks++;
    if (v_l !== 1'b1 || wo_l !== 8'hA5) begin
      errors++; $display("FAIL lsb_first: got valid %b word %h, required 1 a5", v_l, wo_l);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    q_m.push_back(exp_of(8'h3C, 1'b0));
    send_word(0, 8'h3C, 1'b0);
    checks++;
    if (ov_m !== 1'b0) begin
      errors++; $display("FAIL bp_first_overrun: got %b, required 0", ov_m);
    end
    send_word(0, 8'hFF, 1'b0);
    idle(1);
    checks++;
    if (wo_m !== 8'h3C || v_m !== 1'b1 || ov_m !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got word %h valid %b ovr %b, required 3c 1 1", wo_m, v_m, ov_m);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (v_m !== 1'b0 || ov_m !== 1'b1 || wo_m !== 8'h3C) begin
      errors++; $display("FAIL bp_drain: got valid %b ovr %b word %h, required 0 1 3c", v_m, ov_m, wo_m);
    end
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    rst = 1'b1; en_m = 1'b1; d = 1'b1;
    tick();
    rst = 1'b0; en_m = 1'b0;
    checks++;
    if ({wo_m, v_m, ov_m, pe_m} !== 11'd0) begin
      errors++; $display("FAIL midreset_clear: got %h, required 0", {wo_m, v_m, ov_m, pe_m});
    end
    q_m.push_back(exp_of(8'hC3, 1'b0));
    send_word(0, 8'hC3, 1'b0);
    checks++;
    if (wo_m !== 8'hC3 || v_m !== 1'b1) begin
      errors++; $display("FAIL midreset_word: got word %h valid %b, required c3 1", wo_m, v_m);
    end
    idle(2);
  endtask

  task automatic test_drain_and_complete();
    logic [7:0] w;
    ready = 1'b0;
    q_m.push_back(exp_of(8'h11, 1'b0));
    send_word(0, 8'h11, 1'b0);
    w = 8'h22;
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && !PAR) ready = 1'b1;
      if (i == 7 && !PAR) q_m.push_back(exp_of(w, 1'b0));
      send_bit(0, w[7-i]);
    end
    if (PAR) begin
      ready = 1'b1;
      q_m.push_back(exp_of(w, 1'b0));
      send_bit(0, ^w);
    end
    en_m = 1'b0; ready = 1'b0;
    checks++;
    if (wo_m !== 8'h22 || v_m !== 1'b1 || ov_m !== 1'b0) begin
      errors++; $display("FAIL drain_complete: got word %h valid %b ovr %b, required 22 1 0", wo_m, v_m, ov_m);
    end
    ready = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom_range(0, 255));
      q_m.push_back(exp_of(w, 1'b0));
      send_word(0, w, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom_range(0, 255));
      q_l.push_back(exp_of(w, 1'b0));
      send_word(1, w, 1'b0);
    end
    idle(2);
    checks++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
      errors++; $display("FAIL b2b_overrun: got %b %b, required 0 0", ov_m, ov_l);
    end
  endtask

  task automatic test_parity();
    ready = 1'b1;
    q_m.push_back(exp_of(8'hA5, 1'b0));
    send_word(0, 8'hA5, 1'b0);
    checks++;
    if (pe_m !== 1'b0) begin
      errors++; $display("FAIL parity_good: got %b, required 0", pe_m);
    end
    idle(1);
    q_m.push_back(exp_of(8'hA5, 1'b1));
    send_word(0, 8'hA5, 1'b1);
    checks++;
    if (pe_m !== PAR) begin
      errors++; $display("FAIL parity_bad: got %b, required %b", pe_m, PAR);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_lsb_first();
    test_backpressure();
    test_reset_mid_frame();
    test_drain_and_complete();
    test_back_to_back();
    test_parity();
    idle(3);
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q_m.size(), q_l.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
